// File: rtl/pwm_fade_sequencer.sv
// Ramps one pwm_generator channel's compare value toward a commanded target, one clean wr pulse per step.
// Define PWM_FADE_ABORT_EN to let the abort input stop a ramp early; otherwise abort is ignored.
module pwm_fade_sequencer #(
  parameter int COMPARE_SIZE = 8,
  parameter int PERIOD_SIZE  = 16
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [COMPARE_SIZE-1:0] cmd_target,
  input  logic [COMPARE_SIZE-1:0] cmd_step,
  input  logic [PERIOD_SIZE-1:0]  cmd_period,
  input  logic                    abort,
  output logic [COMPARE_SIZE-1:0] compare_out,
  output logic                    wr_out,
  output logic                    busy,
  output logic                    done
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WR_HI | wr_out high, compare_out holds the new level
  // WR_LO | mandatory low gap after the pulse
  // WAIT  | counting down the inter-step period
  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, WAIT} state_t;

  state_t                  state_q;
  logic [COMPARE_SIZE-1:0] level_q;
  logic [COMPARE_SIZE-1:0] target_q;
  logic [COMPARE_SIZE-1:0] step_q;
  logic [PERIOD_SIZE-1:0]  period_q;
  logic [PERIOD_SIZE-1:0]  cnt_q;
  logic                    wr_q;
  logic                    done_q;
  logic                    abort_pend_q;
  logic                    abort_en;
  logic [COMPARE_SIZE-1:0] next_cmd_d;
  logic [COMPARE_SIZE-1:0] next_ramp_d;

`ifdef PWM_FADE_ABORT_EN
  assign abort_en = abort;
`else
  assign abort_en = abort & 1'b0;
`endif

  // Saturating step toward the target; the up path uses one extra bit so it cannot wrap.
  function automatic logic [COMPARE_SIZE-1:0] step_toward(
    input logic [COMPARE_SIZE-1:0] lvl,
    input logic [COMPARE_SIZE-1:0] tgt,
    input logic [COMPARE_SIZE-1:0] stp
  );
    logic [COMPARE_SIZE:0]   sum;
    logic [COMPARE_SIZE-1:0] gap;
    sum = {1'b0, lvl} + {1'b0, stp};
    gap = lvl - tgt;
    if (stp == '0) begin
      return tgt;
    end else if (tgt > lvl) begin
      return (sum >= {1'b0, tgt}) ? tgt : sum[COMPARE_SIZE-1:0];
    end else begin
      return (gap <= stp) ? tgt : lvl - stp;
    end
  endfunction

  assign next_cmd_d  = step_toward(level_q, cmd_target, cmd_step);
  assign next_ramp_d = step_toward(level_q, target_q, step_q);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      target_q     <= '0;
      step_q       <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            target_q     <= cmd_target;
            step_q       <= cmd_step;
            period_q     <= cmd_period;
            abort_pend_q <= 1'b0;
            if (cmd_target == level_q) begin
              done_q <= 1'b1;
            end else begin
              level_q <= next_cmd_d;
              wr_q    <= 1'b1;
              state_q <= WR_HI;
            end
          end
        end
        WR_HI: begin
          wr_q    <= 1'b0;
          state_q <= WR_LO;
          if (abort_en) abort_pend_q <= 1'b1;
        end
        WR_LO: begin
          if (abort_en || abort_pend_q) begin
            abort_pend_q <= 1'b0;
            state_q      <= IDLE;
          end else if (level_q == target_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (period_q == '0) begin
            level_q <= next_ramp_d;
            wr_q    <= 1'b1;
            state_q <= WR_HI;
          end else begin
            cnt_q   <= period_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort_en) begin
            state_q <= IDLE;
          end else if (cnt_q == PERIOD_SIZE'(1)) begin
            cnt_q   <= '0;
            level_q <= next_ramp_d;
            wr_q    <= 1'b1;
            state_q <= WR_HI;
          end else begin
            cnt_q <= cnt_q - PERIOD_SIZE'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign compare_out = level_q;
  assign wr_out      = wr_q;
  assign done        = done_q;

endmodule
